// File: rtl/rr_mux_select_arbiter_if.sv
// Request/grant bundle between the four requesters,
// the select arbiter and the downstream 4:1 mux.
interface rr_mux_select_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       valid;

  modport master (
    output req, done,
    input  gnt, s1, s0, valid
  );

  modport slave (
    input  req, done,
    output gnt, s1, s0, valid
  );
endinterface

// File: rtl/rr_mux_select_arbiter.sv
// Round-robin burst arbiter driving the {s1,s0}
// select of a 4:1 mux, with one-hot grant and valid.
module rr_mux_select_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input logic clk,
  input logic rst,
  rr_mux_select_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [3:0]       gnt_r, gnt_n;
  logic [1:0]       sel, sel_n;
  logic [1:0]       last, last_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic       rel;
  logic       found;
  logic       load;
  logic [1:0] win;
  logic [1:0] idx;
  logic [3:0] elig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_r <= 4'b0000;
      sel   <= 2'b00;
      last  <= 2'b11;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt_r <= gnt_n;
      sel   <= sel_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    rel   = bus.done
          || !bus.req[sel]
          || (cnt == CNT_W'(MAX_BURST));
    elig  = bus.req;
    // A releasing owner that signalled done may not win again.
    if (state == GRANT && bus.done)
      elig[sel] = 1'b0;

    // Scan lowest to highest priority so the last hit wins.
    found = 1'b0;
    win   = last;
    idx   = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    state_n = state;
    gnt_n   = gnt_r;
    sel_n   = sel;
    last_n  = last;
    cnt_n   = cnt;
    load    = 1'b0;

    unique case (state)
      IDLE: begin
        if (found)
          load = 1'b1;
      end
      GRANT: begin
        if (!rel) begin
          cnt_n = cnt + CNT_W'(1);
        end else if (found) begin
          load = 1'b1;
        end else begin
          state_n = IDLE;
          gnt_n   = 4'b0000;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        cnt_n   = '0;
      end
    endcase

    if (load) begin
      state_n = GRANT;
      gnt_n   = 4'b0001 << win;
      sel_n   = win;
      last_n  = win;
      cnt_n   = CNT_W'(1);
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.s1    = sel[1];
  assign bus.s0    = sel[0];
  assign bus.valid = |gnt_r;

endmodule
